// File: rtl/cost_port_arbiter.sv
// cost_port_arbiter: round-robin owner of the single cost-ROM lookup port, bursts of up to 8 beats
// Ports: CLK/RST clock and async active-high reset; req/req_valid/req_last/req_w/req_j per-engine
// burst requests and beat addresses; gnt one-hot owner; W/J address to the ROM; Cost ROM data one
// cycle after W/J; rsp_valid/rsp_cost one-hot response strobe and registered cost; busy burst active.
module cost_port_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [3*NREQ-1:0] req_w,
  input  logic [3*NREQ-1:0] req_j,
  output logic [NREQ-1:0]   gnt,
  output logic [2:0]        W,
  output logic [2:0]        J,
  input  logic [6:0]        Cost,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [6:0]        rsp_cost,
  output logic              busy
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IDW-1:0] ptr, owner, sel, o1, o2;
  logic [2:0] beat_cnt;
  logic found, acc, fin, v1, v2;
  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v % NREQ);
  endfunction
  // descending scan so the lowest offset from ptr is the last (winning) assignment
  always_comb begin
    sel = ptr;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[wrap(int'(ptr) + i)]) begin
        sel = wrap(int'(ptr) + i);
        found = 1'b1;
      end
  end
  assign busy = state == BUSY;
  assign acc = busy && req_valid[owner];
  assign fin = acc && (req_last[owner] || beat_cnt == 3'd7);
  assign gnt = busy ? NREQ'(1) << owner : '0;
  assign W = acc ? req_w[3*owner +: 3] : 3'd0;
  assign J = acc ? req_j[3*owner +: 3] : 3'd0;
  assign rsp_valid = v2 ? NREQ'(1) << o2 : '0;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      beat_cnt <= '0;
      v1 <= 1'b0;
      o1 <= '0;
      v2 <= 1'b0;
      o2 <= '0;
      rsp_cost <= '0;
    end else begin
      v1 <= acc;
      o1 <= owner;
      v2 <= v1;
      o2 <= o1;
      if (v1) rsp_cost <= Cost;
      if (state == IDLE) begin
        if (found) begin
          owner <= sel;
          beat_cnt <= '0;
          state <= BUSY;
        end
      end else if (acc) begin
        beat_cnt <= beat_cnt + 3'd1;
        if (fin) begin
          state <= IDLE;
          ptr <= wrap(int'(owner) + 1);
        end
      end
    end
  end
endmodule

// File: doc/cost_port_arbiter.md
# cost_port_arbiter

Round-robin arbiter that shares the single cost-table lookup port (W/J address out, Cost data back) among NREQ job-assignment evaluation engines. Each engine requests the port for a burst of up to 8 lookups, typically one full permutation with W = 0..7. The burst owner keeps the port until its last beat. The arbiter returns each Cost to the owning engine with a one-hot response strobe. It sits between the parallel permutation engines and the external cost ROM.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester index width, equal to clog2(NREQ)
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- req  in  NREQ  request the port for a burst; held until the grant is seen
- req_valid  in  NREQ  the requester's beat address is valid this cycle
- req_last  in  NREQ  the current beat is the final beat of the burst
- req_w  in  3*NREQ  W address; requester k uses bits [3k+2:3k]
- req_j  in  3*NREQ  J address; same packing as req_w
- gnt  out  NREQ  one-hot port ownership
- W  out  3  cost-table worker index to the ROM
- J  out  3  cost-table job index to the ROM
- Cost  in  7  ROM data; valid one cycle after W/J are presented
- rsp_valid  out  NREQ  one-hot strobe: rsp_cost belongs to this requester
- rsp_cost  out  7  registered Cost
- busy  out  1  a burst is in progress

## Operation
- State machine with two states, IDLE and BUSY.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from ptr, wrapping modulo NREQ.
  - Register owner <= selected index, clear beat_cnt, move to BUSY.
  - If no req bit is set, remain in IDLE.
- BUSY:
  - gnt[owner]=1 and busy=1. Both are decoded from registers only, with no combinational path from req.
  - Beat acceptance: a beat is accepted in any BUSY cycle where req_valid[owner]=1.
  - W/J: combinationally driven from the owner's req_w/req_j slice on an accepted beat; 0 otherwise.
  - beat_cnt (3 bits) increments on every accepted beat.
- Burst end: the accepted beat has req_last[owner]=1, or it is the 8th beat (beat_cnt==7 at acceptance).
  - On burst end: go to IDLE and set ptr <= owner+1, wrapping modulo NREQ.
  - The 8th-beat forced termination happens even when req_last=0.
- Stall: while req_valid[owner]=0, the grant is held and no beats are issued. Deasserting req mid-burst does not release the grant; only a burst end does.
- Requests from non-owners are ignored; they are not lost while req stays high.
- Response path:
  - A two-stage tag pipeline carries (valid, owner) for each accepted beat.
  - rsp_cost <= Cost at the end of cycle t+1, where t is the acceptance cycle.
  - rsp_valid[tag] is high during t+2.
  - rsp_cost holds its value when no response is pending.
- Responses in flight at burst end still complete. They are not affected by the next arbitration.
- Reset, applied asynchronously at any time:
  - State becomes IDLE; ptr=0, owner=0, beat_cnt=0, tag pipeline cleared.
  - Outputs: gnt=0, W=0, J=0, busy=0, rsp_valid=0, rsp_cost=0.
  - Responses in flight at reset are dropped and never strobed.

## Timing
- Arbitration bubble: one IDLE cycle between bursts. A last beat in cycle t gives IDLE at t+1 and a new gnt at t+2.
- First grant after reset release with req present: gnt rises in the 2nd cycle (IDLE decides, BUSY grants).
- Throughput inside a burst: one beat per cycle.
- Acceptance-to-rsp_valid latency: 2 cycles, fixed.
- rsp_valid is at most one-hot, and at most one response is strobed per cycle.
- A requester may assert req_valid in the same cycle gnt first rises; that beat is accepted.

## Test plan
- ROM model Cost = 8*W+J.
  - Stimulus: requester 1 bursts W=0..7, J=3, with last on beat 8.
  - Response: W/J track the beats, and rsp_valid[1] is high for 8 consecutive cycles starting 2 cycles after the first beat.
  - rsp_cost sequence: 3, 11, 19, 27, 35, 43, 51, 59.
- All four req bits high from reset, each sending a 2-beat burst:
  - gnt order is 0,1,2,3,0.
  - Each grant pair is separated by exactly 1 idle cycle.
- Stall: requester 2 drops req_valid for 3 cycles after beat 2.
  - gnt[2] stays high, W=J=0 during the stall, and no rsp_valid pulses for the stalled cycles.
  - Beats resume without loss.
- Forced end: requester 0 sends 9 valid beats with req_last never set.
  - Exactly 8 beats are accepted, then the state goes to IDLE and ptr=1.
  - With requester 3 also requesting, it is granted next.
- Async reset asserted mid-burst, 1 cycle after the 4th beat:
  - gnt, busy and rsp_valid drop immediately.
  - The two pending responses never appear.
  - After release, requester 0 is searched first.
